// File: rtl/uart_frame_receiver.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : uart_frame_receiver                                        |
// | Description : Oversampled UART frame receiver. Frame = 1 start bit (0),  |
// |               DATA_BIT_NUM data bits LSB first, 1 even-parity bit,       |
// |               1 stop bit (1). The line idles high.                       |
// | Ports       : clk        - system clock                                  |
// |               rst_n      - asynchronous active-low reset                  |
// |               os_pulse   - 1-clk strobe at OVERSAMPLE x baud rate         |
// |               sin        - asynchronous serial input, idle high           |
// |               dout       - last received word                             |
// |               dout_valid - 1-clk pulse, frame complete, outputs updated   |
// |               parity_err - last frame failed even-parity check            |
// |               frame_err  - last frame's stop bit sampled 0                |
// |               busy       - receiver is not idle                           |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module uart_frame_receiver #(
  parameter int DATA_BIT_NUM = 8,
  parameter int OVERSAMPLE   = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    os_pulse,
  input  logic                    sin,
  output logic [DATA_BIT_NUM-1:0] dout,
  output logic                    dout_valid,
  output logic                    parity_err,
  output logic                    frame_err,
  output logic                    busy
);

  localparam int OS_CNT_W  = $clog2(OVERSAMPLE);
  // A single data bit still needs a one-bit counter to hold index 0.
  localparam int BIT_CNT_W = (DATA_BIT_NUM > 1) ? $clog2(DATA_BIT_NUM) : 1;

  localparam logic [OS_CNT_W-1:0]  OS_HALF_LAST = OS_CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [OS_CNT_W-1:0]  OS_LAST      = OS_CNT_W'(OVERSAMPLE - 1);
  localparam logic [OS_CNT_W-1:0]  OS_ONE       = OS_CNT_W'(1);
  localparam logic [BIT_CNT_W-1:0] BIT_LAST     = BIT_CNT_W'(DATA_BIT_NUM - 1);
  localparam logic [BIT_CNT_W-1:0] BIT_ONE      = BIT_CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4,
    S_BREAK  = 3'd5
  } state_e;

  // Two-flop synchronizer; both stages reset to the idle (high) level so a
  // reset release never looks like a start edge.
  logic sin_meta_q;
  logic sin_s_q;

  state_e                  state_q,      state_d;
  logic [OS_CNT_W-1:0]     os_cnt_q,     os_cnt_d;
  logic [BIT_CNT_W-1:0]    bit_cnt_q,    bit_cnt_d;
  logic [DATA_BIT_NUM-1:0] shift_q,      shift_d;
  logic                    par_bit_q,    par_bit_d;
  logic [DATA_BIT_NUM-1:0] dout_q,       dout_d;
  logic                    dout_valid_q, dout_valid_d;
  logic                    parity_err_q, parity_err_d;
  logic                    frame_err_q,  frame_err_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sin_meta_q <= 1'b1;
      sin_s_q    <= 1'b1;
    end else begin
      sin_meta_q <= sin;
      sin_s_q    <= sin_meta_q;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      os_cnt_q     <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      par_bit_q    <= 1'b0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      os_cnt_q     <= os_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      par_bit_q    <= par_bit_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
    end
  end

  // Next-state and datapath logic. Everything advances only on os_pulse;
  // dout_valid defaults low so it is a single-clock pulse.
  always_comb begin
    state_d      = state_q;
    os_cnt_d     = os_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    par_bit_d    = par_bit_q;
    dout_d       = dout_q;
    dout_valid_d = 1'b0;
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;

    if (os_pulse) begin
      case (state_q)
        S_IDLE: begin
          if (!sin_s_q) begin
            state_d  = S_START;
            os_cnt_d = '0;
          end
        end

        S_START: begin
          // Re-check the line at mid start bit; a short low glitch is
          // rejected here instead of being taken as a frame.
          if (os_cnt_q == OS_HALF_LAST) begin
            os_cnt_d = '0;
            if (!sin_s_q) begin
              state_d   = S_DATA;
              bit_cnt_d = '0;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            os_cnt_d = os_cnt_q + OS_ONE;
          end
        end

        S_DATA: begin
          if (os_cnt_q == OS_LAST) begin
            os_cnt_d           = '0;
            shift_d[bit_cnt_q] = sin_s_q;
            if (bit_cnt_q == BIT_LAST) begin
              state_d = S_PARITY;
            end else begin
              bit_cnt_d = bit_cnt_q + BIT_ONE;
            end
          end else begin
            os_cnt_d = os_cnt_q + OS_ONE;
          end
        end

        S_PARITY: begin
          if (os_cnt_q == OS_LAST) begin
            os_cnt_d  = '0;
            par_bit_d = sin_s_q;
            state_d   = S_STOP;
          end else begin
            os_cnt_d = os_cnt_q + OS_ONE;
          end
        end

        S_STOP: begin
          if (os_cnt_q == OS_LAST) begin
            os_cnt_d     = '0;
            dout_d       = shift_q;
            parity_err_d = (^shift_q) ^ par_bit_q;
            frame_err_d  = ~sin_s_q;
            dout_valid_d = 1'b1;
            // A low stop bit means the line may be held in break; wait for
            // it to return high before hunting for the next start edge.
            state_d      = sin_s_q ? S_IDLE : S_BREAK;
          end else begin
            os_cnt_d = os_cnt_q + OS_ONE;
          end
        end

        S_BREAK: begin
          if (sin_s_q) begin
            state_d = S_IDLE;
          end
        end

        default: begin
          state_d  = S_IDLE;
          os_cnt_d = '0;
        end
      endcase
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign busy       = (state_q != S_IDLE);

endmodule
`default_nettype wire
